// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and types for the UART receive FIFO controller
package uart_pkg;

    // Word offsets of the register window, taken from mem_addr[3:2]
    localparam logic [1:0] RegRxData = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;
    localparam logic [1:0] RegCtrl   = 2'd2;
    localparam logic [1:0] RegThresh = 2'd3;

    // STATUS bit positions
    localparam int StatNotEmptyBit = 0;
    localparam int StatOverrunBit  = 1;
    localparam int StatFullBit     = 2;
    localparam int StatCountLsb    = 16;

    // CTRL bit positions
    localparam int CtrlIrqEnBit = 0;
    localparam int CtrlFlushBit = 1;

    // RXDATA value returned when nothing is buffered
    localparam logic [31:0] RxEmptyFlag = 32'h0000_0100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } uart_bus_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - CPU data-bus access port of the UART receive controller
interface uart_rx_ctrl_if #(
    parameter int AddrWidth = 4
) ();

    logic                 mem_req;
    logic                 mem_we;
    logic [AddrWidth-1:0] mem_addr;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;
    logic                 mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/uart_rx_fifo_track.sv
// rtl/uart_rx_fifo_track.sv - read index, fill count and overrun tracking for the receive buffer
module uart_rx_fifo_track #(
    parameter  int BufferSizeInt = 64,
    localparam int IdxW          = $clog2(BufferSizeInt),
    localparam int CntW          = IdxW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IdxW-1:0] i_wr_idx,
    input  logic            i_pop,
    input  logic            i_flush,
    input  logic            i_clr_overrun,
    output logic [IdxW-1:0] o_rd_idx,
    output logic [CntW-1:0] o_count,
    output logic            o_overrun
);

    logic [IdxW-1:0] r_wr_idx_q;
    logic [IdxW-1:0] r_rd_idx;
    logic [CntW-1:0] r_count;
    logic            r_overrun;

    logic            w_push;
    logic            w_full;
    logic            w_overrun_push;

    // The receiver moves wr_idx by at most one per cycle, so any change is one byte
    assign w_push         = (i_wr_idx != r_wr_idx_q);
    assign w_full         = (r_count == CntW'(BufferSizeInt));
    // A full buffer plus a new byte means the oldest byte was overwritten,
    // unless a pop frees the slot or a flush discards everything anyway
    assign w_overrun_push = w_push && w_full && !i_pop && !i_flush;

    // Index and count bookkeeping; flush takes priority over any concurrent push
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_idx_q <= '0;
            r_rd_idx   <= '0;
            r_count    <= '0;
        end else begin
            r_wr_idx_q <= i_wr_idx;
            if (i_flush) begin
                r_rd_idx <= i_wr_idx;
                r_count  <= '0;
            end else if (w_push && i_pop) begin
                r_rd_idx <= r_rd_idx + 1'b1;
            end else if (w_overrun_push) begin
                r_rd_idx <= r_rd_idx + 1'b1;
            end else if (w_push) begin
                r_count  <= r_count + 1'b1;
            end else if (i_pop) begin
                r_rd_idx <= r_rd_idx + 1'b1;
                r_count  <= r_count - 1'b1;
            end
        end
    end

    // Sticky overrun flag; a fresh overrun wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_overrun_push) begin
            r_overrun <= 1'b1;
        end else if (i_clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign o_rd_idx  = r_rd_idx;
    assign o_count   = r_count;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - memory-mapped FIFO view of the UART receive buffer
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter  int BufferSizeInt = 64,
    parameter  int AddrWidth     = 4,
    localparam int IdxW          = $clog2(BufferSizeInt),
    localparam int CntW          = IdxW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IdxW-1:0] wr_idx,
    output logic [IdxW-1:0] rd_idx,
    input  logic [7:0]      rd_byte,
    uart_rx_ctrl_if.slave   bus,
    output logic            irq
);

    uart_bus_state_e r_state;
    logic            r_we;
    logic [1:0]      r_reg;
    logic [15:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_ack;
    logic            r_irq_en;
    logic [15:0]     r_thresh;
    logic            r_irq;

    logic            w_access;
    logic            w_empty;
    logic            w_pop;
    logic            w_flush;
    logic            w_clr_overrun;
    logic [CntW-1:0] w_count;
    logic            w_overrun;
    logic [31:0]     w_rdata;

    // Side effects only ever happen in the single ACCESS cycle of a transaction
    assign w_access      = (r_state == ACCESS);
    assign w_empty       = (w_count == '0);
    assign w_pop         = w_access && !r_we && (r_reg == RegRxData) && !w_empty;
    assign w_flush       = w_access && r_we && (r_reg == RegCtrl) && r_wdata[CtrlFlushBit];
    assign w_clr_overrun = w_access && r_we && (r_reg == RegStatus) && r_wdata[StatOverrunBit];

    uart_rx_fifo_track #(
        .BufferSizeInt (BufferSizeInt)
    ) u_fifo_track (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wr_idx      (wr_idx),
        .i_pop         (w_pop),
        .i_flush       (w_flush),
        .i_clr_overrun (w_clr_overrun),
        .o_rd_idx      (rd_idx),
        .o_count       (w_count),
        .o_overrun     (w_overrun)
    );

    // Read data for the latched register, formed from live state during ACCESS
    always_comb begin
        w_rdata = '0;
        case (r_reg)
            RegRxData: begin
                if (w_empty) begin
                    w_rdata = RxEmptyFlag;
                end else begin
                    w_rdata[7:0] = rd_byte;
                end
            end
            RegStatus: begin
                w_rdata[StatNotEmptyBit]        = !w_empty;
                w_rdata[StatOverrunBit]         = w_overrun;
                w_rdata[StatFullBit]            = (w_count == CntW'(BufferSizeInt));
                w_rdata[StatCountLsb +: 16]     = 16'(w_count);
            end
            RegCtrl: begin
                w_rdata[CtrlIrqEnBit] = r_irq_en;
            end
            default: begin
                w_rdata[15:0] = r_thresh;
            end
        endcase
    end

    // Bus sequencer: latch request, act for one cycle, then pulse ack
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_reg   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= 1'b0;
                    if (bus.mem_req) begin
                        r_we    <= bus.mem_we;
                        // The window is four words; the top two address bits pick one
                        r_reg   <= bus.mem_addr[AddrWidth-1 -: 2];
                        r_wdata <= bus.mem_wdata[15:0];
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_rdata <= w_rdata;
                    r_ack   <= 1'b1;
                    r_state <= ACK;
                end
                ACK: begin
                    r_ack   <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Control and threshold registers; a zero threshold would be meaningless, so it becomes 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irq_en <= 1'b0;
            r_thresh <= 16'd1;
        end else if (w_access && r_we) begin
            if (r_reg == RegCtrl) begin
                r_irq_en <= r_wdata[CtrlIrqEnBit];
            end else if (r_reg == RegThresh) begin
                r_thresh <= (r_wdata == 16'd0) ? 16'd1 : r_wdata;
            end
        end
    end

    // Level interrupt, registered so it follows the count one cycle later
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq_en && (16'(w_count) >= r_thresh);
        end
    end

    assign bus.mem_rdata = r_rdata;
    assign bus.mem_ack   = r_ack;
    assign irq           = r_irq;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl at depth 4
module tb_uart_rx_ctrl;

    localparam int Depth = 4;
    localparam int IdxW  = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [IdxW-1:0] wr_idx = '0;
    logic [IdxW-1:0] rd_idx;
    logic [7:0]      rd_byte;
    logic            irq;
    logic [7:0]      rx_buf [Depth];

    int n_vec = 0;
    int n_err = 0;

    uart_rx_ctrl_if #(.AddrWidth(4)) bus ();

    uart_rx_ctrl #(
        .BufferSizeInt (Depth),
        .AddrWidth     (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_idx  (wr_idx),
        .rd_idx  (rd_idx),
        .rd_byte (rd_byte),
        .bus     (bus.slave),
        .irq     (irq)
    );

    assign rd_byte = rx_buf[rd_idx];

    always #5 clk = ~clk;

    task automatic bus_op(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat);
        @(posedge clk); #1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = we;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        lat   = -1;
        rdata = 'x;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            bus.mem_req = 1'b0;
            @(negedge clk);
            if (bus.mem_ack) begin
                lat   = k;
                rdata = bus.mem_rdata;
                break;
            end
        end
    endtask

    task automatic reg_rd(input logic [3:0] addr, output logic [31:0] d);
        int l;
        bus_op(1'b0, addr, 32'h0, d, l);
    endtask

    task automatic reg_wr(input logic [3:0] addr, input logic [31:0] wd);
        logic [31:0] d;
        int l;
        bus_op(1'b1, addr, wd, d, l);
        n_vec++;
        if (l < 0) begin
            n_err++;
            $display("FAIL wr_ack_timeout addr=%h: no ack within 8 cycles", addr);
        end
    endtask

    task automatic push(input logic [7:0] b);
        @(posedge clk); #1;
        rx_buf[wr_idx] = b;
        wr_idx = wr_idx + 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        int l;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.mem_ack !== 1'b0 || rd_idx !== 2'd0 || irq !== 1'b0 || bus.mem_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: ack=%b rd_idx=%0d irq=%b rdata=%h want 0/0/0/0",
                     bus.mem_ack, rd_idx, irq, bus.mem_rdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_op(1'b0, 4'h4, 32'h0, d, l);
        n_vec++;
        if (l !== 2) begin
            n_err++;
            $display("FAIL ack_latency: got %0d want 2", l);
        end
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL status_after_reset: got %h want %h", d, 32'h0);
        end
        @(negedge clk);
        n_vec++;
        if (bus.mem_ack !== 1'b0) begin
            n_err++;
            $display("FAIL ack_one_cycle: got %b want 0", bus.mem_ack);
        end
        reg_rd(4'h0, d);
        n_vec++;
        if (d !== 32'h100 || rd_idx !== 2'd0) begin
            n_err++;
            $display("FAIL rxdata_empty: got %h rd_idx=%0d want 00000100 rd_idx=0", d, rd_idx);
        end
    endtask

    task automatic test_basic;
        logic [31:0] d;
        push(8'h41);
        push(8'h42);
        reg_rd(4'h4, d);
        n_vec++;
        if (d !== 32'h0002_0001) begin
            n_err++;
            $display("FAIL basic_status: got %h want 00020001", d);
        end
        reg_rd(4'h0, d);
        n_vec++;
        if (d !== 32'h41) begin
            n_err++;
            $display("FAIL basic_rd0: got %h want 00000041", d);
        end
        reg_rd(4'h0, d);
        n_vec++;
        if (d !== 32'h42) begin
            n_err++;
            $display("FAIL basic_rd1: got %h want 00000042", d);
        end
        reg_rd(4'h0, d);
        n_vec++;
        if (d !== 32'h100 || rd_idx !== 2'd2) begin
            n_err++;
            $display("FAIL basic_drained: got %h rd_idx=%0d want 00000100 rd_idx=2", d, rd_idx);
        end
    endtask

    task automatic test_overrun;
        logic [31:0] d;
        logic [31:0] exp_b [4];
        exp_b[0] = 32'h11; exp_b[1] = 32'h12; exp_b[2] = 32'h13; exp_b[3] = 32'h14;
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
        reg_rd(4'h4, d);
        n_vec++;
        if (d !== 32'h0004_0007) begin
            n_err++;
            $display("FAIL overrun_status: got %h want 00040007", d);
        end
        for (int i = 0; i < 4; i++) begin
            reg_rd(4'h0, d);
            n_vec++;
            if (d !== exp_b[i]) begin
                n_err++;
                $display("FAIL overrun_rd%0d: got %h want %h", i, d, exp_b[i]);
            end
        end
        reg_rd(4'h4, d);
        n_vec++;
        if (d !== 32'h0000_0002) begin
            n_err++;
            $display("FAIL overrun_sticky: got %h want 00000002", d);
        end
        reg_wr(4'h4, 32'h2);
        reg_rd(4'h4, d);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL overrun_w1c: got %h want 00000000", d);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        push(8'hA3);
        push(8'hA0);
        reg_rd(4'h0, d);
        n_vec++;
        if (d !== 32'hA3) begin
            n_err++;
            $display("FAIL wrap_rd_idx3: got %h want 000000a3", d);
        end
        reg_rd(4'h0, d);
        n_vec++;
        if (d !== 32'hA0) begin
            n_err++;
            $display("FAIL wrap_rd_idx0: got %h want 000000a0", d);
        end
        reg_rd(4'h4, d);
        n_vec++;
        if (d !== 32'h0 || rd_idx !== 2'd1) begin
            n_err++;
            $display("FAIL wrap_end: status=%h rd_idx=%0d want 00000000 rd_idx=1", d, rd_idx);
        end
    endtask

    task automatic test_irq;
        logic [31:0] d;
        reg_wr(4'hC, 32'd3);
        reg_wr(4'h8, 32'h1);
        push(8'h51);
        push(8'h52);
        repeat (3) @(negedge clk);
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_below_thresh: got %b want 0", irq);
        end
        push(8'h53);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_registered_delay: got %b want 0", irq);
        end
        @(negedge clk);
        n_vec++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL irq_at_thresh: got %b want 1", irq);
        end
        reg_rd(4'h0, d);
        n_vec++;
        if (d !== 32'h51) begin
            n_err++;
            $display("FAIL irq_pop_data: got %h want 00000051", d);
        end
        @(negedge clk);
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_after_pop: got %b want 0", irq);
        end
        reg_wr(4'hC, 32'd0);
        reg_rd(4'hC, d);
        n_vec++;
        if (d !== 32'h1) begin
            n_err++;
            $display("FAIL thresh_zero: got %h want 00000001", d);
        end
        reg_rd(4'h8, d);
        n_vec++;
        if (d !== 32'h1) begin
            n_err++;
            $display("FAIL ctrl_readback: got %h want 00000001", d);
        end
    endtask

    task automatic test_flush;
        logic [31:0] d;
        bit seen;
        reg_wr(4'h8, 32'h2);
        reg_rd(4'h4, d);
        n_vec++;
        if (d !== 32'h0 || rd_idx !== 2'd0) begin
            n_err++;
            $display("FAIL flush_plain: status=%h rd_idx=%0d want 00000000 rd_idx=0", d, rd_idx);
        end
        push(8'h61);
        reg_rd(4'h0, d);
        n_vec++;
        if (d !== 32'h61) begin
            n_err++;
            $display("FAIL flush_prep_rd: got %h want 00000061", d);
        end
        push(8'h62);
        push(8'h63);
        push(8'h64);
        reg_rd(4'h4, d);
        n_vec++;
        if (d !== 32'h0003_0001) begin
            n_err++;
            $display("FAIL flush_pre_status: got %h want 00030001", d);
        end
        @(posedge clk); #1;
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 4'h8; bus.mem_wdata = 32'h2;
        @(posedge clk); #1;
        bus.mem_req = 1'b0;
        rx_buf[wr_idx] = 8'h65;
        wr_idx = wr_idx + 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clk);
            if (bus.mem_ack) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL flush_push_ack: no ack within 4 cycles");
        end
        n_vec++;
        if (rd_idx !== 2'd1) begin
            n_err++;
            $display("FAIL flush_push_rd_idx: got %0d want 1", rd_idx);
        end
        reg_rd(4'h4, d);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL flush_push_status: got %h want 00000000", d);
        end
        reg_rd(4'h0, d);
        n_vec++;
        if (d !== 32'h100) begin
            n_err++;
            $display("FAIL flush_push_rxdata: got %h want 00000100", d);
        end
    endtask

    task automatic test_reset_mid_access;
        logic [31:0] d;
        bit seen;
        reg_wr(4'h8, 32'h1);
        push(8'h77);
        @(posedge clk); #1;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 4'h0; bus.mem_wdata = 32'h0;
        @(posedge clk); #1;
        bus.mem_req = 1'b0;
        rst_n  = 1'b0;
        wr_idx = '0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.mem_ack) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL reset_mid_no_ack: ack seen want none");
        end
        n_vec++;
        if (rd_idx !== 2'd0 || irq !== 1'b0 || bus.mem_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_state: rd_idx=%0d irq=%b rdata=%h want 0/0/0",
                     rd_idx, irq, bus.mem_rdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        reg_rd(4'h4, d);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_status: got %h want 00000000", d);
        end
        reg_rd(4'h8, d);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_ctrl: got %h want 00000000", d);
        end
        reg_rd(4'hC, d);
        n_vec++;
        if (d !== 32'h1) begin
            n_err++;
            $display("FAIL reset_mid_thresh: got %h want 00000001", d);
        end
    endtask

    initial begin
        for (int i = 0; i < Depth; i++) rx_buf[i] = 8'h00;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        test_reset();
        test_basic();
        test_overrun();
        test_wrap();
        test_irq();
        test_flush();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
